// File: rtl/bsg_clk_mon_pkg.sv
// ============================================================================
// Module   : bsg_clk_mon_pkg
// Brief    : Shared types for the multi-channel clock monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

`define DECLARE_BSG_CLK_MON_RESULT_S(cnt_width_mp) \
    typedef struct packed {                       \
        logic [cnt_width_mp-1:0] count;           \
        logic                    sat;             \
    } bsg_clk_mon_result_s

package bsg_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } bsg_clk_mon_state_e;

    // One cycle beyond the synchroniser depth also flushes the edge detector.
    localparam int settle_extra_lp = 1;

    function automatic int settle_cycles(input int sync_stages);
        return sync_stages + settle_extra_lp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_clk_mon_if.sv
// ============================================================================
// Module   : bsg_clk_mon_if
// Brief    : Control/result bundle between a host and the clock monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bsg_clk_mon_if #(
    parameter int num_chan_p  = 4,
    parameter int cnt_width_p = 16,
    parameter int win_width_p = 16
);
    logic [num_chan_p-1:0]             chan_en_i;
    logic [win_width_p-1:0]            win_cycles_i;
    logic                              start_i;
    logic                              yumi_i;
    logic                              busy_o;
    logic                              v_o;
    logic [num_chan_p*cnt_width_p-1:0] count_o;
    logic [num_chan_p-1:0]             sat_o;

    modport master (
        output chan_en_i, win_cycles_i, start_i, yumi_i,
        input  busy_o, v_o, count_o, sat_o
    );

    modport slave (
        input  chan_en_i, win_cycles_i, start_i, yumi_i,
        output busy_o, v_o, count_o, sat_o
    );
endinterface

`default_nettype wire

// File: rtl/bsg_clk_mon_chan.sv
// ============================================================================
// Module   : bsg_clk_mon_chan
// Brief    : Per-channel synchroniser, rising-edge detector, saturating counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_clk_mon_chan #(
    parameter int cnt_width_p   = 16,
    parameter int sync_stages_p = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   div_i,
    input  logic                   clear_i,
    input  logic                   count_en_i,
    output logic [cnt_width_p-1:0] count_o,
    output logic                   sat_o
);
    logic [sync_stages_p-1:0] sync_q;
    logic                     prev_q;
    logic [cnt_width_p-1:0]   count_q;
    logic                     sat_q;
    logic                     rise;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages_p-2:0], div_i};
            prev_q <= sync_q[sync_stages_p-1];
        end
    end

    assign rise = sync_q[sync_stages_p-1] & ~prev_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (clear_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (count_en_i && rise) begin
            // A full counter holds; the lost edge is flagged instead.
            if (count_q == {cnt_width_p{1'b1}}) begin
                sat_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

`default_nettype wire

// File: rtl/bsg_clk_mon_multi.sv
// ============================================================================
// Module   : bsg_clk_mon_multi
// Brief    : Multi-channel clock-frequency monitor (FSM, window, packing).
//            BSG_CLK_MON_AUTO_REARM_EN: HOLD+yumi re-enters SETTLE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_clk_mon_multi
    import bsg_clk_mon_pkg::*;
#(
    parameter int num_chan_p    = 4,
    parameter int cnt_width_p   = 16,
    parameter int win_width_p   = 16,
    parameter int sync_stages_p = 2
) (
    input  logic                  clk_i,
    input  logic                  async_reset_n_i,
    input  logic [num_chan_p-1:0] div_clk_i,
    bsg_clk_mon_if.slave          mon_if
);
    localparam int settle_len_lp = settle_cycles(sync_stages_p);
    localparam int settle_w_lp   = $clog2(settle_len_lp);

    `DECLARE_BSG_CLK_MON_RESULT_S(cnt_width_p);

    logic [1:0]             rst_sync_q;
    logic                   rst_n;
    bsg_clk_mon_state_e     state_q;
    logic                   busy_q;
    logic                   v_q;
    logic [num_chan_p-1:0]  en_r_q;
    logic [win_width_p-1:0] win_r_q;
    logic [win_width_p-1:0] win_cnt_q;
    logic [settle_w_lp-1:0] settle_cnt_q;
    logic                   start_go;
    logic                   enter_settle;
    logic                   measure;
    bsg_clk_mon_result_s [num_chan_p-1:0] res;

    // Assert asynchronously, release two clk_i edges later.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign start_go = mon_if.start_i &&
                      ((state_q == IDLE) || ((state_q == HOLD) && mon_if.yumi_i));
`ifdef BSG_CLK_MON_AUTO_REARM_EN
    assign enter_settle = start_go || ((state_q == HOLD) && mon_if.yumi_i);
`else
    assign enter_settle = start_go;
`endif
    assign measure = (state_q == MEASURE);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            v_q          <= 1'b0;
            en_r_q       <= '0;
            win_r_q      <= '0;
            win_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            if (start_go) begin
                en_r_q  <= mon_if.chan_en_i;
                win_r_q <= mon_if.win_cycles_i;
            end
            if (enter_settle) begin
                state_q      <= SETTLE;
                busy_q       <= 1'b1;
                v_q          <= 1'b0;
                settle_cnt_q <= settle_w_lp'(settle_len_lp - 1);
            end else begin
                unique case (state_q)
                    IDLE: ;
                    SETTLE: begin
                        if (settle_cnt_q == '0) begin
                            if (win_r_q == '0) begin
                                state_q <= HOLD;
                                busy_q  <= 1'b0;
                                v_q     <= 1'b1;
                            end else begin
                                state_q   <= MEASURE;
                                win_cnt_q <= win_r_q;
                            end
                        end else begin
                            settle_cnt_q <= settle_cnt_q - 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (win_cnt_q == win_width_p'(1)) begin
                            state_q <= HOLD;
                            busy_q  <= 1'b0;
                            v_q     <= 1'b1;
                        end else begin
                            win_cnt_q <= win_cnt_q - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (mon_if.yumi_i) begin
                            state_q <= IDLE;
                            v_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        v_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < num_chan_p; i++) begin : g_chan
        bsg_clk_mon_chan #(
            .cnt_width_p   (cnt_width_p),
            .sync_stages_p (sync_stages_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_n_i  (rst_n),
            .div_i      (div_clk_i[i]),
            .clear_i    (start_go || enter_settle),
            .count_en_i (measure && en_r_q[i]),
            .count_o    (res[i].count),
            .sat_o      (res[i].sat)
        );

        assign mon_if.count_o[i*cnt_width_p +: cnt_width_p] = res[i].count;
        assign mon_if.sat_o[i]                               = res[i].sat;
    end

    assign mon_if.busy_o = busy_q;
    assign mon_if.v_o    = v_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_clk_mon_multi.sv
// ============================================================================
// Module   : tb_bsg_clk_mon_multi
// Brief    : Self-checking bench for bsg_clk_mon_multi.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_clk_mon_multi;

    typedef struct packed {
        logic [3:0]       en;
        logic [15:0]      win;
        logic [3:0][7:0]  h;
        logic [3:0][15:0] exp;
        logic             flip;
    } vec_t;

    typedef struct packed {
        logic [3:0][15:0] cnt;
        logic [15:0]      lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] div = 4'b0;
    int   half [4] = '{default: 0};
    int   dcnt [4] = '{default: 0};
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    bsg_clk_mon_if mon_if ();
    bsg_clk_mon_if #(.cnt_width_p(4)) sat_if ();

    bsg_clk_mon_multi dut (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .div_clk_i       (div),
        .mon_if          (mon_if)
    );

    bsg_clk_mon_multi #(.cnt_width_p(4)) dut_sat (
        .clk_i           (clk),
        .async_reset_n_i (rst_n),
        .div_clk_i       (div),
        .mon_if          (sat_if)
    );

    // Monitored toggles change on the falling edge; half=0 parks a channel low.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (half[c] == 0) begin
                    div[c]  = 1'b0;
                    dcnt[c] = 0;
                end else begin
                    dcnt[c]++;
                    if (dcnt[c] >= half[c]) begin
                        dcnt[c] = 0;
                        div[c]  = ~div[c];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp);
        int d;
        tests++;
        d = act - exp;
        if ((exp == 0 && act != 0) || d > 1 || d < -1) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (+/-1)", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] en, input int win,
                                input int h0, input int h1, input int h2,
                                input int h3, input bit flip);
        vec_t v;
        int   hh [4];
        hh = '{h0, h1, h2, h3};
        v.en   = en;
        v.win  = 16'(win);
        v.flip = flip;
        for (int c = 0; c < 4; c++) begin
            v.h[c]   = 8'(hh[c]);
            v.exp[c] = (en[c] && hh[c] != 0) ? 16'(win / (2 * hh[c])) : 16'd0;
        end
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_v(input bit flip, input logic [3:0] en, output int cyc);
        cyc = 0;
        while (!mon_if.v_o && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (mon_if.busy_o && mon_if.v_o) chk("busy_and_v", 1, 0);
            if (flip && cyc == 10) mon_if.chan_en_i = ~en;
        end
        if (!mon_if.v_o) chk("v_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int cyc);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, cyc, e.lat);
        for (int c = 0; c < 4; c++)
            chk_tol($sformatf("%s_count%0d", tag, c),
                    int'(mon_if.count_o[c*16 +: 16]), int'(e.cnt[c]));
        chk({tag, "_sat"}, mon_if.sat_o, 0);
    endtask

    task automatic consume();
        mon_if.yumi_i = 1'b1;
        @(posedge clk); #1;
        mon_if.yumi_i = 1'b0;
`ifdef BSG_CLK_MON_AUTO_REARM_EN
        chk("rearm_busy", mon_if.busy_o, 1);
        chk("rearm_v", mon_if.v_o, 0);
        do_reset();
`else
        chk("yumi_v", mon_if.v_o, 0);
        chk("yumi_busy", mon_if.busy_o, 0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   cyc;
        mon_if.chan_en_i    = v.en;
        mon_if.win_cycles_i = v.win;
        for (int c = 0; c < 4; c++) half[c] = int'(v.h[c]);
        repeat (8) @(posedge clk);
        #1;
        mon_if.start_i = 1'b1;
        e.cnt = v.exp;
        e.lat = v.win + 16'd3;
        sbq.push_back(e);
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        chk({tag, "_busy"}, mon_if.busy_o, 1);
        wait_v(v.flip, v.en, cyc);
        check_result(tag, cyc);
        consume();
    endtask

    initial begin
        int   cyc;
        exp_t e;

        vecs[0] = mk(4'hF, 100, 5, 10, 0, 0, 1'b0);
        vecs[1] = mk(4'h5, 100, 5, 5, 5, 5, 1'b1);
        vecs[2] = mk(4'hF, 200, 2, 3, 4, 8, 1'b0);
        vecs[3] = mk(4'hF, 0, 2, 2, 2, 2, 1'b0);
        vecs[4] = mk(4'hA, 37, 3, 3, 3, 3, 1'b0);

        mon_if.chan_en_i = '0; mon_if.win_cycles_i = '0;
        mon_if.start_i = 1'b0; mon_if.yumi_i = 1'b0;
        sat_if.chan_en_i = '0; sat_if.win_cycles_i = '0;
        sat_if.start_i = 1'b0; sat_if.yumi_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", mon_if.busy_o, 0);
        chk("rst_v", mon_if.v_o, 0);
        chk("rst_count", mon_if.count_o, 0);
        chk("rst_sat", mon_if.sat_o, 0);
        chk("rst_sat_dut_v", sat_if.v_o, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Saturation on a 4-bit counter instance.
        half = '{2, 0, 0, 0};
        sat_if.chan_en_i = 4'b0001;
        sat_if.win_cycles_i = 16'd100;
        repeat (4) @(posedge clk);
        #1;
        sat_if.start_i = 1'b1;
        @(posedge clk); #1;
        sat_if.start_i = 1'b0;
        cyc = 0;
        while (!sat_if.v_o && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_latency", cyc, 103);
        chk("sat_count0", sat_if.count_o[3:0], 15);
        chk("sat_flag0", sat_if.sat_o[0], 1);
        chk("sat_flag_hi", sat_if.sat_o[3:1], 0);
        chk("sat_busy_low", sat_if.busy_o, 0);
        sat_if.yumi_i = 1'b1;
        @(posedge clk); #1;
        sat_if.yumi_i = 1'b0;
`ifdef BSG_CLK_MON_AUTO_REARM_EN
        do_reset();
`else
        chk("sat_yumi_v", sat_if.v_o, 0);
`endif

        // Zero window, ignored lone start, then yumi+start back-to-back.
        half = '{5, 5, 5, 5};
        mon_if.chan_en_i = 4'hF;
        mon_if.win_cycles_i = 16'd0;
        mon_if.start_i = 1'b1;
        e.cnt = '0; e.lat = 16'd3;
        sbq.push_back(e);
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        wait_v(1'b0, 4'hF, cyc);
        check_result("win0", cyc);
        mon_if.start_i = 1'b1;
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        @(posedge clk); #1;
        chk("hold_start_v", mon_if.v_o, 1);
        chk("hold_start_busy", mon_if.busy_o, 0);
        mon_if.win_cycles_i = 16'd100;
        mon_if.start_i = 1'b1;
        mon_if.yumi_i = 1'b1;
        e.cnt = {16'd10, 16'd10, 16'd10, 16'd10}; e.lat = 16'd103;
        sbq.push_back(e);
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        mon_if.yumi_i = 1'b0;
        chk("yumi_start_v", mon_if.v_o, 0);
        chk("yumi_start_busy", mon_if.busy_o, 1);
        wait_v(1'b0, 4'hF, cyc);
        check_result("restart", cyc);
        consume();

        // Asynchronous reset in the middle of a window.
        mon_if.start_i = 1'b1;
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_busy", mon_if.busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", mon_if.busy_o, 0);
        chk("arst_v", mon_if.v_o, 0);
        chk("arst_count", mon_if.count_o, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_vec(vecs[0], "post_rst");

`ifdef BSG_CLK_MON_AUTO_REARM_EN
        half = '{5, 10, 0, 0};
        mon_if.chan_en_i = 4'hF;
        mon_if.win_cycles_i = 16'd100;
        repeat (4) @(posedge clk);
        #1;
        mon_if.start_i = 1'b1;
        e.cnt = {16'd0, 16'd0, 16'd5, 16'd10}; e.lat = 16'd103;
        sbq.push_back(e);
        @(posedge clk); #1;
        mon_if.start_i = 1'b0;
        wait_v(1'b0, 4'hF, cyc);
        check_result("rearm0", cyc);
        for (int k = 1; k <= 3; k++) begin
            sbq.push_back(e);
            mon_if.yumi_i = 1'b1;
            @(posedge clk); #1;
            mon_if.yumi_i = 1'b0;
            chk("rearm_loop_busy", mon_if.busy_o, 1);
            wait_v(1'b0, 4'hF, cyc);
            check_result($sformatf("rearm%0d", k), cyc);
        end
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
